// File: rtl/instruction_dispatcher.sv
// instruction_dispatcher: HPS req/ack capture into a small FIFO, one-cycle dispatch strobes,
// with issue held during zoom algorithms (until algo_done or timeout) and after reset opcodes.
module instruction_dispatcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int RESET_HOLD     = 16
) (
  input  logic                        clock_25MHz,
  input  logic                        reset,
  input  logic                        hps_req,
  input  logic [31:0]                 hps_instruction,
  input  logic                        algo_done,
  output logic                        hps_ack,
  output logic [31:0]                 instruction,
  output logic                        enable_instruction,
  output logic                        busy,
  output logic                        error,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES > RESET_HOLD ? TIMEOUT_CYCLES : RESET_HOLD);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WAIT_RST} state_t;
  state_t        r_state;
  logic          r_req_m, r_req_s, r_armed, r_ack, r_en, r_err;
  logic [1:0]    r_warm;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [31:0]   r_instr;
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic [TW-1:0] r_cnt;
  logic          w_pop, w_push;
  logic [2:0]    w_op;
  assign w_pop  = r_state == IDLE && r_count != '0;
  assign w_push = r_armed && r_req_s && !r_ack && (r_count != (AW+1)'(FIFO_DEPTH) || w_pop);
  assign w_op   = r_instr[31:29];
  assign hps_ack            = r_ack;
  assign instruction        = r_instr;
  assign enable_instruction = r_en;
  assign error              = r_err;
  assign fifo_count         = r_count;
  assign busy               = r_count != '0 || r_state != IDLE;
  // A request still high across reset must drop before it can be captured again
  always_ff @(posedge clock_25MHz) begin
    if (reset) begin
      r_req_m <= 1'b0;
      r_req_s <= 1'b0;
      r_warm  <= 2'b00;
      r_armed <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_req_m <= hps_req;
      r_req_s <= r_req_m;
      r_warm  <= {r_warm[0], 1'b1};
      if (r_warm[1] && !r_req_s) r_armed <= 1'b1;
      r_ack   <= w_push ? 1'b1 : (r_req_s ? r_ack : 1'b0);
    end
  end
  always_ff @(posedge clock_25MHz) begin
    if (w_push) r_mem[r_wr] <= hps_instruction;
  end
  always_ff @(posedge clock_25MHz) begin
    if (reset) begin
      r_state <= IDLE;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_err   <= 1'b0;
      r_instr <= '0;
    end else begin
      r_en    <= w_pop;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd    <= r_rd + 1'b1;
        r_instr <= r_mem[r_rd];
      end
      case (r_state)
        IDLE:  if (w_pop) r_state <= ISSUE;
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= (w_op inside {3'b010, 3'b011, 3'b100, 3'b101}) ? WAIT_DONE :
                     (w_op == 3'b110) ? WAIT_RST : IDLE;
        end
        WAIT_DONE: begin
          if (algo_done) r_state <= IDLE;
          else if (r_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          if (r_cnt == TW'(RESET_HOLD - 1)) r_state <= IDLE;
          else r_cnt <= r_cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_dispatcher.sv
// tb_instruction_dispatcher: directed handshake/dispatch scenarios with hand-computed expectations.
module tb_instruction_dispatcher;
  logic        clk = 1'b0, reset = 1'b1, hps_req = 1'b0, algo_done = 1'b0;
  logic [31:0] hps_instruction = '0;
  logic        hps_ack, enable_instruction, busy, error;
  logic [31:0] instruction;
  logic [2:0]  fifo_count;
  int          vecs = 0, errs = 0, cyc = 0, t0, k, n0;
  logic [31:0] en_q[$];
  int          en_t[$];
  logic [31:0] exp4 [6] = '{32'h8000_0000, 32'h2000_0001, 32'h2000_0002,
                            32'h2000_0003, 32'h2000_0004, 32'h2000_0005};

  instruction_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64), .RESET_HOLD(16)) dut (
    .clock_25MHz(clk), .reset(reset), .hps_req(hps_req), .hps_instruction(hps_instruction),
    .algo_done(algo_done), .hps_ack(hps_ack), .instruction(instruction),
    .enable_instruction(enable_instruction), .busy(busy), .error(error), .fifo_count(fifo_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (enable_instruction === 1'b1) begin
    en_q.push_back(instruction);
    en_t.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic v, input string tag);
    int n = 0;
    while (hps_ack !== v && n < 50) begin @(negedge clk); n++; end
    check(tag, {31'd0, hps_ack}, {31'd0, v});
  endtask

  task automatic push_word(input logic [31:0] w);
    @(negedge clk);
    hps_instruction = w;
    hps_req = 1'b1;
    wait_ack(1'b1, "ack_rise");
    hps_req = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic wait_en(input int n);
    int c = 0;
    while (en_q.size() < n && c < 200) begin @(negedge clk); c++; end
    check("enable_count", en_q.size(), n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(4);
    en_q.delete();
    en_t.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, {31'd0, hps_ack}, 0);
    check({tag, "_instr"}, instruction, 0);
    check({tag, "_en"}, {31'd0, enable_instruction}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_err"}, {31'd0, error}, 0);
    check({tag, "_cnt"}, {29'd0, fifo_count}, 0);
  endtask

  initial begin
    idle(2);
    check_zero("reset");
    reset = 1'b0;
    idle(4);
    // 1: single store word
    push_word(32'h2001_2A55);
    idle(8);
    check("t1_n", en_q.size(), 1);
    check("t1_word", en_q[0], 32'h2001_2A55);
    check("t1_busy", {31'd0, busy}, 0);
    check("t1_cnt", {29'd0, fifo_count}, 0);
    check("t1_hold", instruction, 32'h2001_2A55);
    en_q.delete(); en_t.delete();
    // 2: zoom opcode blocks the following store until algo_done
    push_word(32'h6000_0000);
    push_word(32'h2000_0111);
    idle(5);
    check("t2_held", en_q.size(), 1);
    check("t2_cnt", {29'd0, fifo_count}, 1);
    check("t2_busy", {31'd0, busy}, 1);
    @(negedge clk);
    k = cyc;
    algo_done = 1'b1;
    @(negedge clk);
    algo_done = 1'b0;
    wait_en(2);
    check("t2_lat", en_t[1], k + 2);
    check("t2_word", en_q[1], 32'h2000_0111);
    en_q.delete(); en_t.delete();
    // 3: timeout sets sticky error
    push_word(32'h4000_0000);
    wait_en(1);
    t0 = en_t[0];
    while (cyc < t0 + 63) @(negedge clk);
    check("t3_pre", {31'd0, error}, 0);
    while (cyc < t0 + 65) @(negedge clk);
    check("t3_err", {31'd0, error}, 1);
    check("t3_idle", {31'd0, busy}, 0);
    idle(10);
    check("t3_sticky", {31'd0, error}, 1);
    do_reset();
    check("t3_clr", {31'd0, error}, 0);
    // 4: full FIFO stalls the fifth word without loss
    push_word(32'h8000_0000);
    for (int i = 1; i < 5; i++) push_word(exp4[i]);
    check("t4_full", {29'd0, fifo_count}, 4);
    @(negedge clk);
    hps_instruction = exp4[5];
    hps_req = 1'b1;
    idle(8);
    check("t4_stall", {31'd0, hps_ack}, 0);
    check("t4_full2", {29'd0, fifo_count}, 4);
    algo_done = 1'b1;
    @(negedge clk);
    algo_done = 1'b0;
    wait_ack(1'b1, "t4_accept");
    hps_req = 1'b0;
    wait_ack(1'b0, "t4_release");
    wait_en(6);
    for (int i = 0; i < 6; i++) check("t4_order", en_q[i], exp4[i]);
    idle(4);
    check("t4_empty", {29'd0, fifo_count}, 0);
    en_q.delete(); en_t.delete();
    // 5: reset opcode holds issue
    push_word(32'hC000_0000);
    push_word(32'h2000_0777);
    wait_en(2);
    check("t5_gap", en_t[1] - en_t[0], 18);
    check("t5_word", en_q[1], 32'h2000_0777);
    en_q.delete(); en_t.delete();
    // 6: reset while waiting with queued words
    push_word(32'hA000_0000);
    push_word(32'h2000_0A01);
    push_word(32'h2000_0A02);
    push_word(32'h2000_0A03);
    check("t6_queued", {29'd0, fifo_count}, 3);
    check("t6_one", en_q.size(), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("t6");
    reset = 1'b0;
    n0 = en_q.size();
    idle(20);
    check("t6_noen", en_q.size(), n0);
    check("t6_cnt", {29'd0, fifo_count}, 0);
    check("t6_busy", {31'd0, busy}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
